// File: rtl/object_engine_if.sv
// Peripheral-bus view of the object engine: register select, write strobe and read-back data.
interface object_engine_if;
  // Handshake: there is no valid/ready pair. A write is taken in the one cycle
  // write_enable is high; a read is taken when enable && !write_enable and its
  // data appears on data_out after the next clock edge, then holds.
  logic       enable;
  logic [7:0] address;
  logic [7:0] data_in;
  logic       write_enable;
  logic [7:0] data_out;

  modport master (output enable, address, data_in, write_enable, input data_out);
  modport slave  (input enable, address, data_in, write_enable, output data_out);
endinterface

// File: rtl/object_engine.sv
// Movable-object generator: N sprite channels with per-object colour, fixed
// lowest-index priority mixing and pairwise sticky collision latches.
module object_engine #(
  parameter int NUM_OBJECTS = 4,
  parameter int GFX_WIDTH   = 8,
  parameter int POS_WIDTH   = 10,
  parameter int COLOR_WIDTH = 7
) (
  input  logic                   raw_clk,
  input  logic                   reset,
  object_engine_if.slave         bus,
  input  logic                   pixel_en,
  input  logic [POS_WIDTH-1:0]   hpos,
  input  logic [COLOR_WIDTH-1:0] color_bg,
  output logic [COLOR_WIDTH-1:0] pixel_color,
  output logic                   collision_any,
  output logic [NUM_OBJECTS-1:0] dbg_obj_active
);

  localparam logic [3:0] NUM_OBJ_L = 4'(NUM_OBJECTS);
  localparam int         CNT_W     = $clog2(GFX_WIDTH);

  typedef enum logic {S_IDLE, S_ACTIVE} obj_state_t;

  // Bus-visible registers
  logic [POS_WIDTH-1:0]   posx_q    [NUM_OBJECTS];
  logic [GFX_WIDTH-1:0]   gfx_q     [NUM_OBJECTS];
  logic [1:0]             scale_q   [NUM_OBJECTS];
  logic [COLOR_WIDTH-1:0] color_q   [NUM_OBJECTS];
  logic [NUM_OBJECTS-1:0] reflect_q;
  logic [NUM_OBJECTS-1:0] en_q;
  logic [NUM_OBJECTS-1:0] coll_q    [NUM_OBJECTS];

  // Per-object draw state
  obj_state_t             state_q      [NUM_OBJECTS];
  obj_state_t             state_d      [NUM_OBJECTS];
  logic [GFX_WIDTH-1:0]   shift_q      [NUM_OBJECTS];
  logic [GFX_WIDTH-1:0]   shift_d      [NUM_OBJECTS];
  logic [CNT_W-1:0]       bit_cnt_q    [NUM_OBJECTS];
  logic [CNT_W-1:0]       bit_cnt_d    [NUM_OBJECTS];
  logic [2:0]             sub_cnt_q    [NUM_OBJECTS];
  logic [2:0]             sub_cnt_d    [NUM_OBJECTS];
  logic [1:0]             draw_scale_q [NUM_OBJECTS];
  logic [1:0]             draw_scale_d [NUM_OBJECTS];
  logic [NUM_OBJECTS-1:0] obj_on_d;
  logic [NUM_OBJECTS-1:0] obj_on_q;
  logic                   pixel_en_q;
  logic [COLOR_WIDTH-1:0] mix_color;

  // Address decode
  logic [2:0] obj_idx;
  logic       obj_region;
  logic       color_region;
  logic       coll_region;
  logic       clear_coll;
  logic [7:0] rd_data;

  assign obj_idx      = bus.address[4:2];
  assign obj_region   = (bus.address[7:5] == 3'b000) && ({1'b0, obj_idx} < NUM_OBJ_L);
  assign color_region = (bus.address[7:3] == 5'b00100) && ({1'b0, bus.address[2:0]} < NUM_OBJ_L);
  assign coll_region  = (bus.address[7:3] == 5'b00110) && ({1'b0, bus.address[2:0]} < NUM_OBJ_L);
  assign clear_coll   = bus.write_enable && (bus.address == 8'h3F);

  function automatic logic [2:0] sub_reload(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [GFX_WIDTH-1:0] bit_rev(input logic [GFX_WIDTH-1:0] v);
    logic [GFX_WIDTH-1:0] r;
    for (int i = 0; i < GFX_WIDTH; i++) r[i] = v[GFX_WIDTH-1-i];
    return r;
  endfunction

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_OBJECTS; n++) begin
        posx_q[n]  <= '0;
        gfx_q[n]   <= '0;
        scale_q[n] <= '0;
        color_q[n] <= '0;
      end
      reflect_q <= '0;
      en_q      <= '0;
    end else if (bus.write_enable) begin
      for (int n = 0; n < NUM_OBJECTS; n++) begin
        if (obj_region && (obj_idx == 3'(n))) begin
          case (bus.address[1:0])
            2'd0: posx_q[n][7:0]           <= bus.data_in;
            2'd1: posx_q[n][POS_WIDTH-1:8] <= bus.data_in[POS_WIDTH-9:0];
            2'd2: gfx_q[n]                 <= bus.data_in;
            default: begin
              scale_q[n]   <= bus.data_in[1:0];
              reflect_q[n] <= bus.data_in[3];
              en_q[n]      <= bus.data_in[4];
            end
          endcase
        end
        if (color_region && (bus.address[2:0] == 3'(n))) color_q[n] <= bus.data_in[7:1];
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    for (int n = 0; n < NUM_OBJECTS; n++) begin
      if (obj_region && (obj_idx == 3'(n))) begin
        case (bus.address[1:0])
          2'd0:    rd_data = posx_q[n][7:0];
          2'd1:    rd_data = 8'(posx_q[n][POS_WIDTH-1:8]);
          2'd2:    rd_data = gfx_q[n];
          default: rd_data = {3'b000, en_q[n], reflect_q[n], 1'b0, scale_q[n]};
        endcase
      end
      if (color_region && (bus.address[2:0] == 3'(n))) rd_data = {color_q[n], 1'b0};
      if (coll_region && (bus.address[2:0] == 3'(n)))  rd_data = 8'(coll_q[n]);
    end
  end

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      bus.data_out <= 8'h00;
    end else if (bus.enable && !bus.write_enable) begin
      bus.data_out <= rd_data;
    end
  end

  // Object FSMs: state register
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_OBJECTS; n++) begin
        state_q[n]      <= S_IDLE;
        shift_q[n]      <= '0;
        bit_cnt_q[n]    <= '0;
        sub_cnt_q[n]    <= '0;
        draw_scale_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_OBJECTS; n++) begin
        state_q[n]      <= state_d[n];
        shift_q[n]      <= shift_d[n];
        bit_cnt_q[n]    <= bit_cnt_d[n];
        sub_cnt_q[n]    <= sub_cnt_d[n];
        draw_scale_q[n] <= draw_scale_d[n];
      end
    end
  end

  // Graphics and scale are captured at the match, so bus writes mid-line only
  // take effect on the next match; clearing enable is the one exception.
  always_comb begin
    obj_on_d = '0;
    for (int n = 0; n < NUM_OBJECTS; n++) begin
      state_d[n]      = state_q[n];
      shift_d[n]      = shift_q[n];
      bit_cnt_d[n]    = bit_cnt_q[n];
      sub_cnt_d[n]    = sub_cnt_q[n];
      draw_scale_d[n] = draw_scale_q[n];
      if (!en_q[n]) begin
        state_d[n] = S_IDLE;
      end else if (pixel_en) begin
        if (hpos == posx_q[n]) begin
          state_d[n]      = S_ACTIVE;
          shift_d[n]      = reflect_q[n] ? bit_rev(gfx_q[n]) : gfx_q[n];
          bit_cnt_d[n]    = CNT_W'(GFX_WIDTH - 1);
          sub_cnt_d[n]    = sub_reload(scale_q[n]);
          draw_scale_d[n] = scale_q[n];
        end else if (state_q[n] == S_ACTIVE) begin
          if (sub_cnt_q[n] != 3'd0) begin
            sub_cnt_d[n] = sub_cnt_q[n] - 3'd1;
          end else if (bit_cnt_q[n] == '0) begin
            state_d[n] = S_IDLE;
          end else begin
            sub_cnt_d[n] = sub_reload(draw_scale_q[n]);
            shift_d[n]   = shift_q[n] << 1;
            bit_cnt_d[n] = bit_cnt_q[n] - 1'b1;
          end
        end
      end
      obj_on_d[n] = (state_d[n] == S_ACTIVE) && shift_d[n][GFX_WIDTH-1];
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_OBJECTS; n++) dbg_obj_active[n] = (state_q[n] == S_ACTIVE);
  end

  always_comb begin
    mix_color = color_bg;
    for (int n = NUM_OBJECTS - 1; n >= 0; n--) begin
      if (obj_on_q[n]) mix_color = color_q[n];
    end
  end

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      obj_on_q    <= '0;
      pixel_en_q  <= 1'b0;
      pixel_color <= '0;
    end else begin
      obj_on_q   <= obj_on_d;
      pixel_en_q <= pixel_en;
      if (pixel_en_q) pixel_color <= mix_color;
    end
  end

  // A simultaneous overlap beats the clear strobe so no collision is lost.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJECTS; i++) coll_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OBJECTS; i++) begin
        for (int j = 0; j < NUM_OBJECTS; j++) begin
          if (i != j) begin
            if (obj_on_q[i] && obj_on_q[j]) coll_q[i][j] <= 1'b1;
            else if (clear_coll)            coll_q[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    collision_any = 1'b0;
    for (int n = 0; n < NUM_OBJECTS; n++) collision_any = collision_any | (|coll_q[n]);
  end

endmodule

// File: tb/tb_object_engine.sv
// Directed bench for object_engine: register map, line drawing, priority,
// collision latches, mid-line writes, unmapped space and reset.
module tb_object_engine;

  logic       raw_clk = 1'b0;
  logic       reset;
  logic       pixel_en;
  logic [9:0] hpos;
  logic [6:0] color_bg;
  logic [6:0] pixel_color;
  logic       collision_any;
  logic [3:0] dbg_obj_active;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [6:0] cap [64];
  logic [6:0] exp_q [$];

  object_engine_if bus ();

  object_engine #(
    .NUM_OBJECTS(4), .GFX_WIDTH(8), .POS_WIDTH(10), .COLOR_WIDTH(7)
  ) dut (
    .raw_clk        (raw_clk),
    .reset          (reset),
    .bus            (bus),
    .pixel_en       (pixel_en),
    .hpos           (hpos),
    .color_bg       (color_bg),
    .pixel_color    (pixel_color),
    .collision_any  (collision_any),
    .dbg_obj_active (dbg_obj_active)
  );

  // Clock and reset
  always #5 raw_clk = ~raw_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Drivers
  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge raw_clk);
    bus.write_enable = 1'b1;
    bus.address      = addr;
    bus.data_in      = data;
    @(negedge raw_clk);
    bus.write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
    @(negedge raw_clk);
    bus.enable       = 1'b1;
    bus.write_enable = 1'b0;
    bus.address      = addr;
    @(negedge raw_clk);
    bus.enable = 1'b0;
    data       = bus.data_out;
  endtask

  // One pixel_en per cycle for hpos start..start+n-1; cap[i] holds the colour
  // for hpos start+i. Optional bus write is issued alongside pixel wr_at.
  task automatic scan(input int start, input int n, input int wr_at,
                      input logic [7:0] wr_addr, input logic [7:0] wr_data);
    for (int k = 0; k < n + 2; k++) begin
      @(negedge raw_clk);
      if (k >= 2) cap[k-2] = pixel_color;
      bus.write_enable = (k == wr_at);
      if (k == wr_at) begin
        bus.address = wr_addr;
        bus.data_in = wr_data;
      end
      pixel_en = (k < n);
      hpos     = 10'(start + k);
    end
  endtask

  task automatic check_line(input string name, input int start, input int n);
    logic [6:0] e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (cap[i] !== e) begin
        n_errors++;
        $display("FAIL %s hpos=%0d: got %h expected %h", name, start + i, cap[i], e);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    n_checks++;
    if (pixel_color !== 7'h00) begin n_errors++; $display("FAIL reset_pixel_color: got %h expected 00", pixel_color); end
    n_checks++;
    if (collision_any !== 1'b0) begin n_errors++; $display("FAIL reset_collision_any: got %b expected 0", collision_any); end
    n_checks++;
    if (dbg_obj_active !== 4'b0000) begin n_errors++; $display("FAIL reset_active: got %b expected 0000", dbg_obj_active); end
    n_checks++;
    if (bus.data_out !== 8'h00) begin n_errors++; $display("FAIL reset_data_out: got %h expected 00", bus.data_out); end
    bus_read(8'h02, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_errors++; $display("FAIL reset_gfx0: got %h expected 00", rd); end
  endtask

  task automatic test_registers();
    logic [7:0] rd;
    bus_write(8'h05, 8'hFF);
    bus_read(8'h05, rd);
    n_checks++;
    if (rd !== 8'h03) begin n_errors++; $display("FAIL posx_hi_rb: got %h expected 03", rd); end
    bus_write(8'h04, 8'hC8);
    bus_read(8'h04, rd);
    n_checks++;
    if (rd !== 8'hC8) begin n_errors++; $display("FAIL posx_lo_rb: got %h expected c8", rd); end
    bus_write(8'h0B, 8'hFF);
    bus_read(8'h0B, rd);
    n_checks++;
    if (rd !== 8'h1B) begin n_errors++; $display("FAIL ctrl_rb: got %h expected 1b", rd); end
    bus_write(8'h0B, 8'h00);
    bus_write(8'h20, 8'h24);
    bus_read(8'h20, rd);
    n_checks++;
    if (rd !== 8'h24) begin n_errors++; $display("FAIL color_rb: got %h expected 24", rd); end
    repeat (3) @(negedge raw_clk);
    n_checks++;
    if (bus.data_out !== 8'h24) begin n_errors++; $display("FAIL data_out_hold: got %h expected 24", bus.data_out); end
    bus_write(8'h04, 8'h00);
    bus_write(8'h05, 8'h00);
  endtask

  task automatic test_basic_line();
    bus_write(8'h21, 8'h68);
    bus_write(8'h22, 8'h8E);
    bus_write(8'h00, 8'h64);
    bus_write(8'h01, 8'h00);
    bus_write(8'h02, 8'hA5);
    bus_write(8'h03, 8'h10);
    scan(98, 12, -1, 8'h00, 8'h00);
    exp_q = {7'h05, 7'h05, 7'h12, 7'h05, 7'h12, 7'h05, 7'h05, 7'h12, 7'h05, 7'h12, 7'h05, 7'h05};
    check_line("basic_line", 98, 12);
  endtask

  task automatic test_scale_reflect();
    logic [7:0] pat;
    int p;
    pat = 8'h83;  // 0xC1 drawn LSB first
    bus_write(8'h02, 8'hC1);
    bus_write(8'h03, 8'h1A);
    scan(99, 36, -1, 8'h00, 8'h00);
    for (int i = 0; i < 36; i++) begin
      p = 99 + i;
      if (p >= 100 && p < 132 && pat[7 - (p - 100) / 4]) exp_q.push_back(7'h12);
      else exp_q.push_back(7'h05);
    end
    check_line("scale_reflect", 99, 36);
    n_checks++;
    if (dbg_obj_active !== 4'b0000) begin n_errors++; $display("FAIL scale_end_idle: got %b expected 0000", dbg_obj_active); end
  endtask

  task automatic test_hold();
    bus_write(8'h02, 8'hF0);
    bus_write(8'h03, 8'h10);
    scan(100, 2, -1, 8'h00, 8'h00);
    repeat (5) @(negedge raw_clk);
    n_checks++;
    if (pixel_color !== 7'h12) begin n_errors++; $display("FAIL hold_color: got %h expected 12", pixel_color); end
    n_checks++;
    if (dbg_obj_active !== 4'b0001) begin n_errors++; $display("FAIL hold_active: got %b expected 0001", dbg_obj_active); end
    scan(102, 6, -1, 8'h00, 8'h00);
    exp_q = {7'h12, 7'h12, 7'h05, 7'h05, 7'h05, 7'h05};
    check_line("hold_resume", 102, 6);
  endtask

  task automatic test_collision();
    logic [7:0] rd;
    bus_write(8'h00, 8'h32);
    bus_write(8'h02, 8'hFF);
    bus_write(8'h03, 8'h10);
    bus_write(8'h04, 8'h32);
    bus_write(8'h06, 8'hFF);
    bus_write(8'h07, 8'h10);
    scan(48, 12, -1, 8'h00, 8'h00);
    exp_q = {7'h05, 7'h05, 7'h12, 7'h12, 7'h12, 7'h12, 7'h12, 7'h12, 7'h12, 7'h12, 7'h05, 7'h05};
    check_line("overlap_priority", 48, 12);
    bus_read(8'h30, rd);
    n_checks++;
    if (rd !== 8'h02) begin n_errors++; $display("FAIL coll_row0: got %h expected 02", rd); end
    bus_read(8'h31, rd);
    n_checks++;
    if (rd !== 8'h01) begin n_errors++; $display("FAIL coll_row1: got %h expected 01", rd); end
    bus_read(8'h32, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_errors++; $display("FAIL coll_row2: got %h expected 00", rd); end
    n_checks++;
    if (collision_any !== 1'b1) begin n_errors++; $display("FAIL coll_any_set: got %b expected 1", collision_any); end
    bus_write(8'h3F, 8'h00);
    bus_read(8'h30, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_errors++; $display("FAIL coll_row0_clr: got %h expected 00", rd); end
    bus_read(8'h31, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_errors++; $display("FAIL coll_row1_clr: got %h expected 00", rd); end
    n_checks++;
    if (collision_any !== 1'b0) begin n_errors++; $display("FAIL coll_any_clr: got %b expected 0", collision_any); end
  endtask

  task automatic test_clear_race();
    logic [7:0] rd;
    // Clear lands on the last overlapping pixel (hpos 57 seen by the latches)
    scan(48, 12, 10, 8'h3F, 8'h00);
    bus_read(8'h30, rd);
    n_checks++;
    if (rd !== 8'h02) begin n_errors++; $display("FAIL race_row0: got %h expected 02", rd); end
    bus_read(8'h31, rd);
    n_checks++;
    if (rd !== 8'h01) begin n_errors++; $display("FAIL race_row1: got %h expected 01", rd); end
    bus_write(8'h3F, 8'h00);
    bus_write(8'h03, 8'h00);
    bus_write(8'h07, 8'h00);
  endtask

  task automatic test_priority_partial();
    logic [7:0] rd;
    bus_write(8'h04, 8'hC8);
    bus_write(8'h06, 8'hF0);
    bus_write(8'h07, 8'h10);
    bus_write(8'h08, 8'hCA);
    bus_write(8'h09, 8'h00);
    bus_write(8'h0A, 8'hFF);
    bus_write(8'h0B, 8'h10);
    scan(198, 13, -1, 8'h00, 8'h00);
    exp_q = {7'h05, 7'h05, 7'h34, 7'h34, 7'h34, 7'h34, 7'h47, 7'h47, 7'h47, 7'h47, 7'h47, 7'h47, 7'h05};
    check_line("partial_priority", 198, 13);
    bus_read(8'h31, rd);
    n_checks++;
    if (rd !== 8'h04) begin n_errors++; $display("FAIL partial_row1: got %h expected 04", rd); end
    bus_read(8'h32, rd);
    n_checks++;
    if (rd !== 8'h02) begin n_errors++; $display("FAIL partial_row2: got %h expected 02", rd); end
    bus_read(8'h30, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_errors++; $display("FAIL partial_row0: got %h expected 00", rd); end
    bus_write(8'h07, 8'h00);
    bus_write(8'h0B, 8'h00);
    bus_write(8'h3F, 8'h00);
  endtask

  task automatic test_mid_write();
    bus_write(8'h00, 8'h64);
    bus_write(8'h02, 8'hF0);
    bus_write(8'h03, 8'h10);
    scan(98, 14, 4, 8'h02, 8'h0F);
    exp_q = {7'h05, 7'h05, 7'h12, 7'h12, 7'h12, 7'h12, 7'h05, 7'h05, 7'h05, 7'h05, 7'h05, 7'h05, 7'h05, 7'h05};
    check_line("midwrite_old", 98, 14);
    scan(98, 14, -1, 8'h00, 8'h00);
    exp_q = {7'h05, 7'h05, 7'h05, 7'h05, 7'h05, 7'h05, 7'h12, 7'h12, 7'h12, 7'h12, 7'h05, 7'h05, 7'h05, 7'h05};
    check_line("midwrite_new", 98, 14);
    bus_write(8'h02, 8'hFF);
    scan(98, 14, 5, 8'h03, 8'h00);
    exp_q = {7'h05, 7'h05, 7'h12, 7'h12, 7'h12, 7'h12, 7'h05, 7'h05, 7'h05, 7'h05, 7'h05, 7'h05, 7'h05, 7'h05};
    check_line("enable_clear", 98, 14);
    n_checks++;
    if (dbg_obj_active !== 4'b0000) begin n_errors++; $display("FAIL enable_clear_idle: got %b expected 0000", dbg_obj_active); end
  endtask

  task automatic test_unmapped();
    logic [7:0] rd;
    logic [7:0] addrs [8];
    addrs = '{8'h10, 8'h12, 8'h13, 8'h24, 8'h27, 8'h2F, 8'h34, 8'h40};
    for (int i = 0; i < 8; i++) bus_write(addrs[i], 8'hFE);
    for (int i = 0; i < 8; i++) begin
      bus_read(addrs[i], rd);
      n_checks++;
      if (rd !== 8'h00) begin n_errors++; $display("FAIL unmapped_%h: got %h expected 00", addrs[i], rd); end
    end
    bus_read(8'h02, rd);
    n_checks++;
    if (rd !== 8'hFF) begin n_errors++; $display("FAIL no_alias_gfx0: got %h expected ff", rd); end
    bus_read(8'h20, rd);
    n_checks++;
    if (rd !== 8'h24) begin n_errors++; $display("FAIL no_alias_color0: got %h expected 24", rd); end
  endtask

  task automatic test_reset_mid_draw();
    logic [7:0] rd;
    bus_write(8'h00, 8'h32);
    bus_write(8'h03, 8'h10);
    bus_write(8'h04, 8'h32);
    bus_write(8'h05, 8'h00);
    bus_write(8'h06, 8'hFF);
    bus_write(8'h07, 8'h10);
    scan(48, 6, -1, 8'h00, 8'h00);
    n_checks++;
    if (cap[5] !== 7'h12) begin n_errors++; $display("FAIL pre_reset_color: got %h expected 12", cap[5]); end
    n_checks++;
    if (collision_any !== 1'b1) begin n_errors++; $display("FAIL pre_reset_coll: got %b expected 1", collision_any); end
    @(negedge raw_clk);
    reset = 1'b1;
    @(negedge raw_clk);
    n_checks++;
    if (pixel_color !== 7'h00) begin n_errors++; $display("FAIL mid_reset_color: got %h expected 00", pixel_color); end
    n_checks++;
    if (collision_any !== 1'b0) begin n_errors++; $display("FAIL mid_reset_coll: got %b expected 0", collision_any); end
    n_checks++;
    if (dbg_obj_active !== 4'b0000) begin n_errors++; $display("FAIL mid_reset_active: got %b expected 0000", dbg_obj_active); end
    reset = 1'b0;
    bus_read(8'h31, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_errors++; $display("FAIL mid_reset_row1: got %h expected 00", rd); end
    bus_read(8'h20, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_errors++; $display("FAIL mid_reset_color0: got %h expected 00", rd); end
  endtask

  initial begin
    reset            = 1'b1;
    pixel_en         = 1'b0;
    hpos             = '0;
    color_bg         = 7'h05;
    bus.enable       = 1'b0;
    bus.write_enable = 1'b0;
    bus.address      = 8'h00;
    bus.data_in      = 8'h00;
    repeat (3) @(negedge raw_clk);
    reset = 1'b0;

    test_reset();
    test_registers();
    test_basic_line();
    test_scale_reflect();
    test_hold();
    test_collision();
    test_clear_race();
    test_priority_partial();
    test_mid_write();
    test_unmapped();
    test_reset_mid_draw();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/object_engine.md
Name: object_engine

Overview:
- Parametrised movable-object (sprite) generator with N independent channels, each with its own position, graphics, width scale, reflection, enable and colour.
- Adds what the fixed two-player/two-missile datapath lacks: a configurable object count, a per-object colour mux with fixed priority, and pairwise collision latches readable over the bus.
- Sits on the 8-bit peripheral bus beside the UART and HDMI timing. It takes hpos and a pixel-advance strobe, and emits one registered colour per pixel.

Parameters:
- NUM_OBJECTS, 4, number of object channels (1..8).
- GFX_WIDTH, 8, graphics bits per object line (fixed 8 for bus-register mapping; other values reserved).
- POS_WIDTH, 10, width of hpos and object X position.
- COLOR_WIDTH, 7, colour index width (colour written as data_in[7:1]).

Ports:
- raw_clk  input  1  system clock; everything in this block runs on it.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  bus select for reads.
- address  input  8  register address.
- data_in  input  8  write data.
- write_enable  input  1  bus write strobe (one raw_clk cycle per access).
- data_out  output  8  registered read data.
- pixel_en  input  1  one-cycle strobe when hpos advances.
- hpos  input  POS_WIDTH  current horizontal pixel position.
- color_bg  input  COLOR_WIDTH  colour used when no object is lit.
- pixel_color  output  COLOR_WIDTH  registered output colour.
- collision_any  output  1  OR of all collision latch bits.

Behaviour:
- Register map, per object n (n < NUM_OBJECTS), base 4n:
  - +0 posx[7:0]
  - +1 posx[9:8] from data_in[1:0]
  - +2 graphics[7:0]
  - +3 ctrl: [1:0] scale (0=1, 1=2, 2=4, 3=8 pixels per bit), [3] reflect, [4] enable
- 0x20+n: color_n <= data_in[7:1].
- 0x30+n: read collision row n. Bit m = 1 means objects n and m overlapped; bit n always reads 0.
- 0x3F: any write clears all collision latches.
- Registers for n >= NUM_OBJECTS and unmapped addresses: writes ignored, reads return 0.
- Reads occur when enable && !write_enable; data_out updates on the next raw_clk edge and holds otherwise. Registers listed above read back their written value; 0x20+n reads back {color_n,1'b0}.
- Per-object FSM:
  - IDLE -> ACTIVE on pixel_en && enable_n && hpos == posx_n.
  - On entry, latch graphics (bit-reversed if reflect), set bit_cnt = GFX_WIDTH-1, set sub_cnt = scale_pixels-1.
  - In ACTIVE, per pixel_en: if sub_cnt != 0, decrement sub_cnt; else reload sub_cnt and shift. ACTIVE -> IDLE after the last sub-pixel of bit 0.
  - A position match while ACTIVE restarts the draw with fresh latched graphics.
  - obj_on_n = ACTIVE && shifter MSB, registered.
  - Writes to graphics, ctrl or posx during ACTIVE do not affect the current draw, except clearing enable, which forces IDLE on the next cycle.
  - Outside pixel_en cycles the state and counters hold.
- Latency: match at cycle t (pixel_en) -> obj_on valid at t+1 -> pixel_color at t+2. Total 2 raw_clk cycles, constant.
- Priority: lowest index lit object wins; none lit -> color_bg. pixel_color updates only on cycles following pixel_en and holds otherwise.
- Collision:
  - On each cycle where obj_on_i && obj_on_j (i != j), set latch bits [i][j] and [j][i].
  - Latches are sticky until a 0x3F write.
  - Clear and a new set in the same cycle: set wins.
- Reset: all registers, colours, collision latches, data_out and pixel_color = 0; all objects IDLE; collision_any = 0.
- Wrap: posx values above the maximum hpos never match, so the object is invisible; no wrap-around drawing.

Test Plan:
- Obj0 posx=100, gfx=0xA5, scale=0, enabled, color 0x12 (write 0x24), color_bg=0x05 -> pixel_color for hpos 100..107 = 12,05,12,05,05,12,05,12 (hex), appearing 2 cycles after each pixel_en.
- Same, scale=2 (4x), reflect=1 -> each bit held 4 pixels, bit order reversed, 32 pixels total, then color_bg.
- Obj0 and obj1 both at posx=50, gfx=0xFF -> obj0 colour shown; read 0x30 = 0x02, read 0x31 = 0x01; collision_any = 1. Write 0x3F -> reads 0, collision_any = 0.
- Overlap active in the same cycle as a 0x3F write -> latch remains set.
- Rewrite gfx from 0xF0 to 0x0F mid-draw -> current line still shows 0xF0; next match shows 0x0F. Clear enable mid-draw -> output returns to color_bg within 2 cycles.
- NUM_OBJECTS=2: write 0x08..0x0B and 0x22 -> no effect, reads return 0. Assert reset mid-draw -> pixel_color = 0 next cycle and all latches clear.
